rotor_stage: RTL and testbench
==============================

// Module: rotor_stage
// PURPOSE
//  Clocked, parametrised Enigma rotor. Holds its own position and ring setting,
//  and steps on command with a notch carry for chaining rotors.
//  Maps a one-hot contact vector through a wiring permutation, with both a forward path and a reverse (return) path.
//  Sits between the keyboard/plugboard and the reflector; three or more instances are chained by the stepping controller.
// PARAMETERS
//  ALPHA   26           number of contacts / letters
//  PW      5            position width, 2**PW >= ALPHA
//  NOTCH   16           position at which a step emits carry_out (16 = 'Q')
//  WIRING  team default packed ALPHA*PW wiring table; W[x] = WIRING[x*PW +: PW];
//          default W = 17,20,12,23,9,10,15,18,25,4,5,24,2,16,21,6,13,0,7,22,1,14,19,3,11,8 (x=0..25)
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  load      in   1      load pos_in and ring_in this edge
//  pos_in    in   PW     new rotor position
//  ring_in   in   PW     new ring setting
//  step_in   in   1      advance position by one this edge
//  in_valid  in   1      fwd_in/rev_in hold a contact to map this edge
//  fwd_in    in   ALPHA  forward-path contacts (one-hot nominal)
//  rev_in    in   ALPHA  reverse-path contacts
//  fwd_out   out  ALPHA  registered forward result
//  rev_out   out  ALPHA  registered reverse result
//  out_valid out  1      fwd_out/rev_out valid
//  pos       out  PW     current position register
//  at_notch  out  1      comb: pos == NOTCH (used by controller for double-step)
//  carry_out out  1      comb: step_in & (pos == NOTCH)
// BEHAVIOUR
//  Reset (async, immediate): pos=0, ring=0, fwd_out=0, rev_out=0, out_valid=0.
//  Position update per edge, priority: load > step_in > hold.
//   - load: pos <= (pos_in<ALPHA ? pos_in : 0), ring <= (ring_in<ALPHA ? ring_in : 0).
//   - step_in: pos <= (pos==ALPHA-1) ? 0 : pos+1.
//   - load and step_in together: load wins, no step, carry_out still follows the comb formula.
//  Offset: off = (pos - ring) mod ALPHA, from the register values BEFORE the edge.
//  Contact map: s(x) = (W[(x+off) mod ALPHA] - off) mod ALPHA; all mod in PW+1 bits, no overflow.
//  Mapping is a bit permutation, not an encoder. Per bit x:
//   - fwd_out[s(x)] <= fwd_in[x]
//   - rev_out[x] <= rev_in[s(x)]
//   - all-zero input -> all-zero output; multi-hot is permuted bitwise.
//  Latency: 1 cycle. out_valid <= in_valid.
//  When in_valid=0, fwd_out/rev_out hold their last value.
//  Mapping while stepping or loading on the same edge uses the old pos/ring (key press precedes rotation).
//  W must be a permutation; rev path must be the true inverse (rev(fwd(x)) == x) at every off.
//  Do not use any property of W beyond its being a permutation.
//  No combinational path from fwd_in/rev_in to outputs.
//  carry_out/at_notch are comb from pos/step_in only.
//  Reset asserted mid-operation clears state at once.
//  out_valid is low on the first edge after reset release unless in_valid was high.
// TESTING
//  1 Reset with pos/outputs nonzero -> all outputs 0 without a clock edge.
//  2 pos=0, ring=0, in_valid=1, fwd_in=1<<0 -> next cycle fwd_out=1<<17, out_valid=1.
//  3 load pos_in=1, ring_in=0; then fwd_in=1<<0 -> fwd_out=1<<19.
//  4 load pos_in=25; step_in=1 -> pos=0, carry_out=0.
//    Then load 16 and step -> carry_out=1 during step, pos=17.
//  5 load+step_in same edge with pos_in=3 -> pos=3.
//    load pos_in=30 -> pos=0.
//  6 Sweep all pos/ring (26x26) and x: feed fwd result into rev_in -> rev_out == 1<<x.
//    fwd_in=0 -> fwd_out=0.

Source files
------------

// File: rtl/rotor_stage.sv
// Clocked Enigma rotor: position/ring registers with notch carry, and a
// registered forward/return contact permutation through the wiring table.
module rotor_stage #(
  parameter int ALPHA = 26,
  parameter int PW    = 5,
  parameter int NOTCH = 16,
  parameter logic [ALPHA*PW-1:0] WIRING = {
    5'd8,  5'd11, 5'd3,  5'd19, 5'd14, 5'd1,  5'd22, 5'd7,  5'd0,
    5'd13, 5'd6,  5'd21, 5'd16, 5'd2,  5'd24, 5'd5,  5'd4,  5'd25,
    5'd18, 5'd15, 5'd10, 5'd9,  5'd23, 5'd12, 5'd20, 5'd17}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [PW-1:0]    pos_in,
  input  logic [PW-1:0]    ring_in,
  input  logic             step_in,
  input  logic             in_valid,
  input  logic [ALPHA-1:0] fwd_in,
  input  logic [ALPHA-1:0] rev_in,
  output logic [ALPHA-1:0] fwd_out,
  output logic [ALPHA-1:0] rev_out,
  output logic             out_valid,
  output logic [PW-1:0]    pos,
  output logic             at_notch,
  output logic             carry_out
);

  localparam logic [PW:0] ALPHA_W = (PW+1)'(ALPHA);

  // (a - b) mod ALPHA for operands already in range; PW+1 bits avoid wrap.
  function automatic logic [PW-1:0] mod_sub(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + ALPHA_W - {1'b0, b};
    return d[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ALPHA_W) s = s - ALPHA_W;
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] wire_at(input logic [PW-1:0] idx);
    return WIRING[int'(idx)*PW +: PW];
  endfunction

  logic [PW-1:0]    ring;
  logic [PW-1:0]    off_p0;
  logic [PW-1:0]    smap_p0 [ALPHA];
  logic [ALPHA-1:0] fwd_map_p0;
  logic [ALPHA-1:0] rev_map_p0;

  assign at_notch  = (pos == PW'(NOTCH));
  assign carry_out = step_in & at_notch;

  // Stage p0: contact permutation from the pre-edge position and ring.
  always_comb begin
    off_p0     = mod_sub(pos, ring);
    smap_p0    = '{default: '0};
    fwd_map_p0 = '0;
    rev_map_p0 = '0;
    for (int x = 0; x < ALPHA; x++) begin
      smap_p0[x] = mod_sub(wire_at(mod_add(PW'(x), off_p0)), off_p0);
    end
    for (int x = 0; x < ALPHA; x++) begin
      for (int y = 0; y < ALPHA; y++) begin
        if (smap_p0[x] == PW'(y)) begin
          fwd_map_p0[y] = fwd_in[x];
          rev_map_p0[x] = rev_in[y];
        end
      end
    end
  end

  // Stage p1: registered outputs and rotor state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos       <= '0;
      ring      <= '0;
      fwd_out   <= '0;
      rev_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        fwd_out <= fwd_map_p0;
        rev_out <= rev_map_p0;
      end
      if (load) begin
        pos  <= ({1'b0, pos_in}  < ALPHA_W) ? pos_in  : '0;
        ring <= ({1'b0, ring_in} < ALPHA_W) ? ring_in : '0;
      end else if (step_in) begin
        pos <= (pos == PW'(ALPHA-1)) ? '0 : pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Directed bench for rotor_stage: reset, mapping, stepping/notch, load rules
// and a full position/ring/contact round-trip sweep.
module tb_rotor_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [4:0]  pos_in = '0;
  logic [4:0]  ring_in = '0;
  logic        step_in = 1'b0;
  logic        in_valid = 1'b0;
  logic [25:0] fwd_in = '0;
  logic [25:0] rev_in = '0;
  logic [25:0] fwd_out;
  logic [25:0] rev_out;
  logic        out_valid;
  logic [4:0]  pos;
  logic        at_notch;
  logic        carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  int wtab [26] = '{17,20,12,23,9,10,15,18,25,4,5,24,2,16,21,6,13,0,7,22,1,14,19,3,11,8};

  rotor_stage dut (
    .clock(clock), .reset(reset), .load(load), .pos_in(pos_in), .ring_in(ring_in),
    .step_in(step_in), .in_valid(in_valid), .fwd_in(fwd_in), .rev_in(rev_in),
    .fwd_out(fwd_out), .rev_out(rev_out), .out_valid(out_valid), .pos(pos),
    .at_notch(at_notch), .carry_out(carry_out)
  );

  always #5 clock = ~clock;

  function automatic int smodel(input int x, input int p, input int r);
    int off;
    off = (p - r + 26) % 26;
    return (wtab[(x + off) % 26] - off + 26) % 26;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_rotor(input int p, input int r);
    load = 1'b1; pos_in = 5'(p); ring_in = 5'(r);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    load_rotor(5, 2);
    in_valid = 1'b1; fwd_in = 26'h3; rev_in = 26'h1;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL reset_pos got %0d want 0", pos); end
    n_cmp++; if (fwd_out !== 26'd0) begin n_bad++; $display("FAIL reset_fwd got %h want 0", fwd_out); end
    n_cmp++; if (rev_out !== 26'd0) begin n_bad++; $display("FAIL reset_rev got %h want 0", rev_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", out_valid); end
    #3;
    reset = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_vld got %b want 0", out_valid); end
  endtask

  task automatic test_map();
    in_valid = 1'b1; fwd_in = 26'd1 << 0;
    tick();
    n_cmp++; if (fwd_out !== (26'd1 << 17)) begin n_bad++; $display("FAIL map_p0 got %h want %h", fwd_out, 26'd1 << 17); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL map_vld got %b want 1", out_valid); end
    // multi-hot: bits 0 and 1 map to 17 and 20
    fwd_in = 26'h3;
    tick();
    n_cmp++; if (fwd_out !== ((26'd1 << 17) | (26'd1 << 20))) begin n_bad++; $display("FAIL map_multi got %h want %h", fwd_out, (26'd1 << 17) | (26'd1 << 20)); end
    fwd_in = 26'd0;
    tick();
    n_cmp++; if (fwd_out !== 26'd0) begin n_bad++; $display("FAIL map_zero got %h want 0", fwd_out); end
    // hold when not valid
    fwd_in = 26'd1 << 0;
    tick();
    in_valid = 1'b0; fwd_in = 26'd1 << 5;
    tick();
    n_cmp++; if (fwd_out !== (26'd1 << 17)) begin n_bad++; $display("FAIL map_hold got %h want %h", fwd_out, 26'd1 << 17); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_vld got %b want 0", out_valid); end
    load_rotor(1, 0);
    in_valid = 1'b1; fwd_in = 26'd1 << 0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (fwd_out !== (26'd1 << 19)) begin n_bad++; $display("FAIL map_p1 got %h want %h", fwd_out, 26'd1 << 19); end
  endtask

  task automatic test_step();
    load_rotor(25, 0);
    step_in = 1'b1;
    n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL carry_25 got %b want 0", carry_out); end
    tick();
    step_in = 1'b0;
    n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL wrap_pos got %0d want 0", pos); end
    load_rotor(16, 0);
    n_cmp++; if (at_notch !== 1'b1) begin n_bad++; $display("FAIL at_notch got %b want 1", at_notch); end
    n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL carry_nostep got %b want 0", carry_out); end
    step_in = 1'b1;
    #1;
    n_cmp++; if (carry_out !== 1'b1) begin n_bad++; $display("FAIL carry_16 got %b want 1", carry_out); end
    tick();
    step_in = 1'b0;
    n_cmp++; if (pos !== 5'd17) begin n_bad++; $display("FAIL step_pos got %0d want 17", pos); end
    n_cmp++; if (at_notch !== 1'b0) begin n_bad++; $display("FAIL notch_17 got %b want 0", at_notch); end
  endtask

  task automatic test_load_rules();
    load = 1'b1; step_in = 1'b1; pos_in = 5'd3; ring_in = 5'd0;
    tick();
    load = 1'b0; step_in = 1'b0;
    n_cmp++; if (pos !== 5'd3) begin n_bad++; $display("FAIL load_step_pos got %0d want 3", pos); end
    load_rotor(30, 30);
    n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL load_oor_pos got %0d want 0", pos); end
    // out-of-range ring also cleared: off 0 -> contact 0 maps to 17; step on same edge uses old pos
    in_valid = 1'b1; step_in = 1'b1; fwd_in = 26'd1 << 0;
    tick();
    in_valid = 1'b0; step_in = 1'b0;
    n_cmp++; if (fwd_out !== (26'd1 << 17)) begin n_bad++; $display("FAIL oldpos_map got %h want %h", fwd_out, 26'd1 << 17); end
    n_cmp++; if (pos !== 5'd1) begin n_bad++; $display("FAIL oldpos_step got %0d want 1", pos); end
  endtask

  task automatic test_sweep();
    logic [25:0] want;
    for (int p = 0; p < 26; p++) begin
      for (int r = 0; r < 26; r++) begin
        load_rotor(p, r);
        for (int x = 0; x < 26; x++) begin
          in_valid = 1'b1; fwd_in = 26'd1 << x; rev_in = 26'd0;
          tick();
          want = 26'd1 << smodel(x, p, r);
          n_cmp++;
          if (fwd_out !== want) begin
            n_bad++; $display("FAIL sweep_fwd p=%0d r=%0d x=%0d got %h want %h", p, r, x, fwd_out, want);
          end
          fwd_in = 26'd0; rev_in = fwd_out;
          tick();
          n_cmp++;
          if (rev_out !== (26'd1 << x)) begin
            n_bad++; $display("FAIL sweep_rev p=%0d r=%0d x=%0d got %h want %h", p, r, x, rev_out, 26'd1 << x);
          end
          n_cmp++;
          if (fwd_out !== 26'd0) begin
            n_bad++; $display("FAIL sweep_zero p=%0d r=%0d got %h want 0", p, r, fwd_out);
          end
        end
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_map();
    test_step();
    test_load_rules();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
